lt24_run_controller: RTL and testbench

- Synthesisable, parametrised run controller for MiniProject bring-up, usable both in simulation and on hardware.
- Generates the application reset, then waits for display initialisation (resetApp low) with a timeout.
- Then meters execution in fixed-length cycle chunks, counting LT24 pixel/command writes per chunk.
- Sits between the top-level clock/reset and the MiniProject instance. Provides chunked "run/stop" control and a throughput readout in logic rather than in bench code.

---
 rtl/lt24_run_pkg.sv | 29 ++
 rtl/lt24_write_counter.sv | 52 +++++
 rtl/lt24_run_controller.sv | 142 ++++++++++++++
 tb/tb_lt24_run_controller.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lt24_run_pkg.sv
// Shared state encoding and saturating arithmetic for the LT24 run controller.
package lt24_run_pkg;

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_INIT = 3'd1,
        RUN       = 3'd2,
        PAUSE     = 3'd3,
        DONE      = 3'd4,
        TIMEOUT   = 3'd5
    } state_t;

    localparam int unsigned SAT_W = 64;

    // Increment by one when inc is set, holding at the all-ones value of a width-bit counter.
    function automatic logic [SAT_W-1:0] sat_inc(
        input logic [SAT_W-1:0] value,
        input logic             inc,
        input int unsigned      width
    );
        logic [SAT_W-1:0] max_value;
        max_value = (width >= SAT_W) ? '1 : ((SAT_W'(1) << width) - SAT_W'(1));
        if (inc && (value < max_value)) begin
            return value + SAT_W'(1);
        end
        return value;
    endfunction

endpackage

// File: rtl/lt24_write_counter.sv
// Counts qualified LT24 write strobes (rising Wr_n with CS_n low) per chunk and in total.
module lt24_write_counter
    import lt24_run_pkg::*;
#(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_n,
    input  logic             cs_n,
    input  logic             count_en,
    input  logic             clear,
    input  logic             latch,
    output logic [CNT_W-1:0] chunk_writes,
    output logic [CNT_W-1:0] total_writes
);

    logic             wr_n_q;
    logic             write_c;
    logic [CNT_W-1:0] chunk_cnt;
    logic [CNT_W-1:0] chunk_inc_c;
    logic [CNT_W-1:0] total_inc_c;

    assign write_c     = count_en & ~wr_n_q & wr_n & ~cs_n;
    assign chunk_inc_c = CNT_W'(sat_inc(SAT_W'(chunk_cnt), write_c, CNT_W));
    assign total_inc_c = CNT_W'(sat_inc(SAT_W'(total_writes), write_c, CNT_W));

    // A latch captures the running chunk count including a write seen on the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_n_q       <= 1'b1;
            chunk_cnt    <= '0;
            chunk_writes <= '0;
            total_writes <= '0;
        end else begin
            wr_n_q <= wr_n;
            if (clear) begin
                chunk_cnt    <= '0;
                total_writes <= '0;
            end else begin
                total_writes <= total_inc_c;
                if (latch) begin
                    chunk_writes <= chunk_inc_c;
                    chunk_cnt    <= '0;
                end else begin
                    chunk_cnt <= chunk_inc_c;
                end
            end
        end
    end

endmodule

// File: rtl/lt24_run_controller.sv
// Bring-up run controller: app reset, init wait with timeout, chunked run/pause metering.
module lt24_run_controller
    import lt24_run_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned INIT_TIMEOUT = 1000000,
    parameter int unsigned CHUNK_CYCLES = 100000,
    parameter int unsigned NUM_CHUNKS   = 0,
    parameter int unsigned PAUSE_EN     = 1,
    parameter int unsigned CYC_W        = 32,
    parameter int unsigned CNT_W        = 24
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             resetApp,
    input  logic             LT24Wr_n,
    input  logic             LT24CS_n,
    input  logic             resume,
    output logic             appResetOut,
    output logic             initDone,
    output logic             chunkDone,
    output logic             running,
    output logic             paused,
    output logic             finished,
    output logic             timedOut,
    output logic             errReinit,
    output logic [CNT_W-1:0] chunkIndex,
    output logic [CNT_W-1:0] chunkWrites,
    output logic [CNT_W-1:0] totalWrites
);

    localparam logic [CYC_W-1:0] HOLD_LAST    = CYC_W'(RESET_CYCLES - 32'd1);
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'((INIT_TIMEOUT == 32'd0) ? 32'd0 : INIT_TIMEOUT - 32'd1);
    localparam logic [CYC_W-1:0] CHUNK_LAST   = CYC_W'(CHUNK_CYCLES - 32'd1);

    state_t           state;
    logic [CYC_W-1:0] cnt;
    logic             chunk_end_c;
    logic             count_en_c;
    logic             init_go_c;
    logic             last_chunk_c;
    logic [CNT_W-1:0] index_next_c;

    assign chunk_end_c  = (state == RUN) && (cnt == CHUNK_LAST);
    assign count_en_c   = (state == RUN) || (state == PAUSE);
    assign init_go_c    = (state == WAIT_INIT) && !resetApp;
    assign index_next_c = CNT_W'(sat_inc(SAT_W'(chunkIndex), 1'b1, CNT_W));
    assign last_chunk_c = (NUM_CHUNKS != 32'd0) && (SAT_W'(index_next_c) == SAT_W'(NUM_CHUNKS));

    // One counter serves as hold timer, init timeout and chunk cycle count, cleared on each hand-off.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= HOLD;
            cnt         <= '0;
            appResetOut <= 1'b1;
            initDone    <= 1'b0;
            chunkDone   <= 1'b0;
            running     <= 1'b0;
            paused      <= 1'b0;
            finished    <= 1'b0;
            timedOut    <= 1'b0;
            errReinit   <= 1'b0;
            chunkIndex  <= '0;
        end else begin
            initDone  <= 1'b0;
            chunkDone <= 1'b0;
            case (state)
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state       <= WAIT_INIT;
                        appResetOut <= 1'b0;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + CYC_W'(1);
                    end
                end
                WAIT_INIT: begin
                    if (!resetApp) begin
                        state    <= RUN;
                        running  <= 1'b1;
                        initDone <= 1'b1;
                        cnt      <= '0;
                    end else if ((INIT_TIMEOUT != 32'd0) && (cnt == TIMEOUT_LAST)) begin
                        state    <= TIMEOUT;
                        timedOut <= 1'b1;
                    end else begin
                        cnt <= cnt + CYC_W'(1);
                    end
                end
                RUN: begin
                    if (resetApp) begin
                        errReinit <= 1'b1;
                    end
                    if (chunk_end_c) begin
                        chunkDone  <= 1'b1;
                        chunkIndex <= index_next_c;
                        cnt        <= '0;
                        if (last_chunk_c) begin
                            state    <= DONE;
                            running  <= 1'b0;
                            finished <= 1'b1;
                        end else if (PAUSE_EN != 32'd0) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                            paused  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CYC_W'(1);
                    end
                end
                PAUSE: begin
                    if (resetApp) begin
                        errReinit <= 1'b1;
                    end
                    if (resume) begin
                        state   <= RUN;
                        paused  <= 1'b0;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    lt24_write_counter #(
        .CNT_W (CNT_W)
    ) u_write_counter (
        .clock        (clock),
        .reset        (reset),
        .wr_n         (LT24Wr_n),
        .cs_n         (LT24CS_n),
        .count_en     (count_en_c),
        .clear        (init_go_c),
        .latch        (chunk_end_c),
        .chunk_writes (chunkWrites),
        .total_writes (totalWrites)
    );

endmodule

// File: tb/tb_lt24_run_controller.sv
// Self-checking bench: two controller configurations against a cycle-level behavioural model.
module tb_lt24_run_controller;

    localparam int NI = 2;
    localparam int PH_HOLD  = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_PAUSE = 3;
    localparam int PH_DONE  = 4;
    localparam int PH_TO    = 5;

    typedef struct {
        int rc; int to; int ch; int nc; int pe; int w;
    } cfg_t;

    typedef struct {
        int phase; int hold_left; int waited; int run_n;
        int chunk_w; int total_w; int idx; int last_w;
        bit prev; bit app; bit init_p; bit done_p; bit err;
    } mdl_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst [NI];
    logic rapp[NI];
    logic wr  [NI];
    logic cs  [NI];
    logic res [NI];

    cfg_t cfg[NI];
    mdl_t mdl[NI];
    bit   started = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic a_app, a_init, a_cd, a_run, a_pau, a_fin, a_to, a_err;
    logic [23:0] a_idx, a_cw, a_tw;
    logic b_app, b_init, b_cd, b_run, b_pau, b_fin, b_to, b_err;
    logic [1:0] b_idx, b_cw, b_tw;

    lt24_run_controller #(
        .RESET_CYCLES(2), .INIT_TIMEOUT(50), .CHUNK_CYCLES(10), .NUM_CHUNKS(3),
        .PAUSE_EN(1), .CYC_W(32), .CNT_W(24)
    ) dut_a (
        .clock(clock), .reset(rst[0]), .resetApp(rapp[0]), .LT24Wr_n(wr[0]), .LT24CS_n(cs[0]),
        .resume(res[0]), .appResetOut(a_app), .initDone(a_init), .chunkDone(a_cd),
        .running(a_run), .paused(a_pau), .finished(a_fin), .timedOut(a_to), .errReinit(a_err),
        .chunkIndex(a_idx), .chunkWrites(a_cw), .totalWrites(a_tw)
    );

    lt24_run_controller #(
        .RESET_CYCLES(2), .INIT_TIMEOUT(0), .CHUNK_CYCLES(10), .NUM_CHUNKS(0),
        .PAUSE_EN(0), .CYC_W(16), .CNT_W(2)
    ) dut_b (
        .clock(clock), .reset(rst[1]), .resetApp(rapp[1]), .LT24Wr_n(wr[1]), .LT24CS_n(cs[1]),
        .resume(res[1]), .appResetOut(b_app), .initDone(b_init), .chunkDone(b_cd),
        .running(b_run), .paused(b_pau), .finished(b_fin), .timedOut(b_to), .errReinit(b_err),
        .chunkIndex(b_idx), .chunkWrites(b_cw), .totalWrites(b_tw)
    );

    function automatic int satv(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // One clock of the controller as described behaviourally: phases, counts, saturation at readout.
    function automatic mdl_t step(input mdl_t m, input cfg_t c, input bit r, input bit ra,
                                  input bit w, input bit csn, input bit rs);
        bit wr_ev;
        if (r) begin
            m = '{default: 0};
            m.phase     = PH_HOLD;
            m.hold_left = c.rc;
            m.prev      = 1'b1;
            m.app       = 1'b1;
            return m;
        end
        wr_ev    = (m.phase == PH_RUN || m.phase == PH_PAUSE) && !m.prev && w && !csn;
        m.prev   = w;
        m.init_p = 1'b0;
        m.done_p = 1'b0;
        if (wr_ev) begin
            m.chunk_w++;
            m.total_w++;
        end
        case (m.phase)
            PH_HOLD: begin
                m.hold_left--;
                if (m.hold_left == 0) begin
                    m.phase = PH_WAIT;
                    m.app   = 1'b0;
                end
            end
            PH_WAIT: begin
                m.waited++;
                if (!ra) begin
                    m.phase  = PH_RUN;
                    m.init_p = 1'b1;
                end else if (c.to != 0 && m.waited == c.to) begin
                    m.phase = PH_TO;
                end
            end
            PH_RUN: begin
                if (ra) m.err = 1'b1;
                m.run_n++;
                if (m.run_n == c.ch) begin
                    m.done_p  = 1'b1;
                    m.last_w  = m.chunk_w;
                    m.chunk_w = 0;
                    m.run_n   = 0;
                    m.idx++;
                    if (c.nc != 0 && satv(m.idx, c.w) == c.nc) m.phase = PH_DONE;
                    else if (c.pe != 0) m.phase = PH_PAUSE;
                end
            end
            PH_PAUSE: begin
                if (ra) m.err = 1'b1;
                if (rs) m.phase = PH_RUN;
            end
            default: ;
        endcase
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_inst(input int i, input logic app, input logic init, input logic cd,
                            input logic run, input logic pau, input logic fin, input logic tmo,
                            input logic err, input logic [31:0] idx, input logic [31:0] cw,
                            input logic [31:0] tw);
        mdl_t m;
        cfg_t c;
        m = mdl[i];
        c = cfg[i];
        check($sformatf("i%0d appResetOut", i), 32'(app), 32'(m.app));
        check($sformatf("i%0d initDone", i), 32'(init), 32'(m.init_p));
        check($sformatf("i%0d chunkDone", i), 32'(cd), 32'(m.done_p));
        check($sformatf("i%0d running", i), 32'(run), 32'(m.phase == PH_RUN));
        check($sformatf("i%0d paused", i), 32'(pau), 32'(m.phase == PH_PAUSE));
        check($sformatf("i%0d finished", i), 32'(fin), 32'(m.phase == PH_DONE));
        check($sformatf("i%0d timedOut", i), 32'(tmo), 32'(m.phase == PH_TO));
        check($sformatf("i%0d errReinit", i), 32'(err), 32'(m.err));
        check($sformatf("i%0d chunkIndex", i), idx, 32'(satv(m.idx, c.w)));
        check($sformatf("i%0d chunkWrites", i), cw, 32'(satv(m.last_w, c.w)));
        check($sformatf("i%0d totalWrites", i), tw, 32'(satv(m.total_w, c.w)));
    endtask

    always @(posedge clock) begin
        for (int i = 0; i < NI; i++) begin
            mdl[i] = step(mdl[i], cfg[i], rst[i], rapp[i], wr[i], cs[i], res[i]);
        end
        started = 1'b1;
    end

    always @(negedge clock) begin
        if (started) begin
            chk_inst(0, a_app, a_init, a_cd, a_run, a_pau, a_fin, a_to, a_err,
                     32'(a_idx), 32'(a_cw), 32'(a_tw));
            chk_inst(1, b_app, b_init, b_cd, b_run, b_pau, b_fin, b_to, b_err,
                     32'(b_idx), 32'(b_cw), 32'(b_tw));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic do_reset(input int i, input int n);
        rst[i] = 1'b1;
        tick(n);
        rst[i] = 1'b0;
    endtask

    // Resume from PAUSE, then drive one chunk of random strobes and count the qualified ones.
    task automatic run_random_chunk(input int i, output int n);
        bit prev;
        bit wv;
        bit cv;
        res[i] = 1'b1;
        tick();
        res[i] = 1'b0;
        prev = wr[i];
        n = 0;
        for (int j = 0; j < 10; j++) begin
            wv = 1'($urandom_range(0, 1));
            cv = 1'($urandom_range(0, 1));
            if (!prev && wv && !cv) n++;
            prev = wv;
            wr[i] = wv;
            cs[i] = cv;
            tick();
        end
    endtask

    task automatic random_phase(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            rst[i]  = ($urandom_range(0, 149) == 0);
            rapp[i] = ($urandom_range(0, 11) == 0);
            wr[i]   = 1'($urandom_range(0, 1));
            cs[i]   = ($urandom_range(0, 3) == 0);
            res[i]  = ($urandom_range(0, 4) == 0);
            tick();
        end
        rst[i] = 1'b0;
        res[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1);
    end

    initial begin
        int k;
        int n;
        int gap;
        cfg[0] = '{rc: 2, to: 50, ch: 10, nc: 3, pe: 1, w: 24};
        cfg[1] = '{rc: 2, to: 0, ch: 10, nc: 0, pe: 0, w: 2};
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; rapp[i] = 1'b1; wr[i] = 1'b1; cs[i] = 1'b1; res[i] = 1'b0;
        end
        tick(2);

        // Init timeout on A; resume during WAIT_INIT and TIMEOUT must be ignored.
        do_reset(0, 3);
        tick();
        check("A hold cycle1 appResetOut", 32'(a_app), 32'd1);
        tick();
        check("A hold cycle2 appResetOut", 32'(a_app), 32'd0);
        res[0] = 1'b1;
        tick();
        res[0] = 1'b0;
        tick(48);
        check("A wait49 timedOut", 32'(a_to), 32'd0);
        tick();
        check("A wait50 timedOut", 32'(a_to), 32'd1);
        res[0] = 1'b1;
        tick();
        res[0] = 1'b0;
        rapp[0] = 1'b0;
        tick(3);
        check("A timeout sticky", 32'(a_to), 32'd1);
        check("A timeout no run", 32'(a_run), 32'd0);

        // Normal run on A: init at cycle 7, 4 qualified of 5 edges in chunk 0.
        rapp[0] = 1'b1; wr[0] = 1'b1; cs[0] = 1'b1;
        do_reset(0, 3);
        tick(6);
        rapp[0] = 1'b0;
        tick();
        check("A initDone pulse", 32'(a_init), 32'd1);
        check("A running after init", 32'(a_run), 32'd1);
        k = $urandom_range(0, 4);
        for (int j = 0; j < 10; j++) begin
            wr[0] = 1'(j % 2);
            cs[0] = ((j % 2 == 1) && (j / 2 == k)) ? 1'b1 : 1'b0;
            tick();
            if (j == 0) check("A initDone single", 32'(a_init), 32'd0);
        end
        check("A chunk0 chunkDone", 32'(a_cd), 32'd1);
        check("A chunk0 chunkWrites", 32'(a_cw), 32'd4);
        check("A chunk0 chunkIndex", 32'(a_idx), 32'd1);
        check("A chunk0 paused", 32'(a_pau), 32'd1);
        cs[0] = 1'b0;
        for (int j = 0; j < 6; j++) begin
            wr[0] = 1'(j % 2);
            tick();
        end
        wr[0] = 1'b1;
        tick(14);
        check("A still paused", 32'(a_pau), 32'd1);
        run_random_chunk(0, n);
        check("A chunk1 chunkWrites", 32'(a_cw), 32'(3 + n));
        check("A chunk1 chunkIndex", 32'(a_idx), 32'd2);
        tick(3);
        run_random_chunk(0, n);
        check("A chunk2 finished", 32'(a_fin), 32'd1);
        check("A chunk2 chunkIndex", 32'(a_idx), 32'd3);
        res[0] = 1'b1;
        tick();
        res[0] = 1'b0;
        tick(3);
        check("A done ignores resume", 32'(a_run), 32'd0);
        check("A finished sticky", 32'(a_fin), 32'd1);

        // errReinit in RUN, then reset mid-chunk.
        rapp[0] = 1'b1; wr[0] = 1'b1; cs[0] = 1'b0;
        do_reset(0, 2);
        tick(4);
        rapp[0] = 1'b0;
        tick();
        for (int j = 0; j < 3; j++) begin
            wr[0] = 1'(j % 2);
            tick();
        end
        rapp[0] = 1'b1;
        wr[0] = 1'b1;
        tick();
        rapp[0] = 1'b0;
        check("A errReinit set", 32'(a_err), 32'd1);
        check("A errReinit keeps running", 32'(a_run), 32'd1);
        tick(2);
        rst[0] = 1'b1;
        tick();
        check("A midreset appResetOut", 32'(a_app), 32'd1);
        check("A midreset errReinit", 32'(a_err), 32'd0);
        check("A midreset totalWrites", 32'(a_tw), 32'd0);
        check("A midreset running", 32'(a_run), 32'd0);
        rst[0] = 1'b0;
        tick();
        check("A release cycle1 appResetOut", 32'(a_app), 32'd1);
        tick();
        check("A release cycle2 appResetOut", 32'(a_app), 32'd0);
        random_phase(0, 400);

        // B: no timeout, free-run, 2-bit saturating counters.
        rapp[1] = 1'b1; wr[1] = 1'b1; cs[1] = 1'b0;
        do_reset(1, 3);
        tick(202);
        check("B no timeout", 32'(b_to), 32'd0);
        rapp[1] = 1'b0;
        tick();
        check("B running", 32'(b_run), 32'd1);
        for (int j = 0; j < 10; j++) begin
            wr[1] = 1'(j % 2);
            tick();
        end
        check("B chunkDone", 32'(b_cd), 32'd1);
        check("B chunkWrites saturated", 32'(b_cw), 32'd3);
        check("B totalWrites saturated", 32'(b_tw), 32'd3);
        gap = -1;
        for (int j = 1; j <= 30; j++) begin
            tick();
            if (b_cd === 1'b1) begin
                gap = j;
                break;
            end
        end
        check("B chunkDone spacing", 32'(gap), 32'd10);
        tick(35);
        check("B chunkIndex saturated", 32'(b_idx), 32'd3);
        check("B free-run not paused", 32'(b_pau), 32'd0);
        random_phase(1, 300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
